kbd_autotype: RTL and testbench

Scripted key-injection controller that sits in front of the keyboard matrix block's ps2_key input. It accepts queued {shift, scancode} entries, for example from a paste/type-in loader. For each entry it emits timed PS/2-style press and release events (with a shift wrap when needed) in the 11-bit toggle protocol. Live keyboard events are merged with priority on the same output bus.

---
 rtl/kbd_autotype.sv | 120 ++++++++++++
 tb/tb_kbd_autotype.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/kbd_autotype.sv
// kbd_autotype: queues {shift, scancode} entries and types them as PS/2 toggle events, merged with live keys
module kbd_autotype #(
  parameter int FIFO_DEPTH = 16,
  parameter int HOLD_CYCLES = 400000,
  parameter int GAP_CYCLES = 400000,
  parameter int CNT_W = 24
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key_in,
  output logic [10:0] ps2_key_out,
  input  logic        wr_en,
  input  logic [8:0]  wr_data,
  input  logic        abort,
  output logic        full,
  output logic        busy,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, SHIFT_DN, KEY_DN, HOLD, KEY_UP, SHIFT_UP, GAP} state_t;
  state_t state, state_d;
  logic [8:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count, count_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [8:0] cur;
  logic [7:0] emit_code;
  logic unwind, unwind_d, key_q, primed, live, abort_t, abort_go, push, pop, emit, emit_press;
  assign live = primed && (ps2_key_in[10] != key_q);
  assign abort_t = abort || (live && ps2_key_in[9] && busy);
  assign abort_go = abort_t && !unwind;
  assign push = wr_en && !full && !abort_t;
  assign pop = state == IDLE && count != '0 && !abort_t;
  assign count_d = count + CW'(push) - CW'(pop);
  assign emit_code = (state == SHIFT_DN || state == SHIFT_UP) ? 8'h12 : cur[7:0];
  assign emit_press = state == SHIFT_DN || state == KEY_DN;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    unwind_d = unwind;
    emit = 1'b0;
    case (state)
      IDLE: state_d = pop ? (mem[rp][8] ? SHIFT_DN : KEY_DN) : IDLE;
      SHIFT_DN: begin
        emit = !abort_go && !live;
        state_d = abort_go ? IDLE : (live ? SHIFT_DN : KEY_DN);
      end
      KEY_DN: begin
        emit = !abort_go && !live;
        unwind_d = abort_go;
        state_d = abort_go ? (cur[8] ? SHIFT_UP : IDLE) : (live ? KEY_DN : HOLD);
        cnt_d = CNT_W'(HOLD_CYCLES - 1);
      end
      HOLD: begin
        unwind_d = abort_go;
        state_d = (abort_go || cnt == '0) ? KEY_UP : HOLD;
        cnt_d = (cnt == '0) ? cnt : cnt - CNT_W'(1);
      end
      KEY_UP, SHIFT_UP: begin
        emit = !live;
        unwind_d = unwind || abort_go;
        state_d = live ? state : ((state == KEY_UP && cur[8]) ? SHIFT_UP : ((unwind || abort_go) ? IDLE : GAP));
        cnt_d = CNT_W'(GAP_CYCLES - 1);
      end
      GAP: begin
        state_d = (abort_go || cnt == '0) ? IDLE : GAP;
        cnt_d = (cnt == '0) ? cnt : cnt - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) unwind_d = 1'b0;
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      unwind <= 1'b0;
      cur <= '0;
      key_q <= 1'b0;
      primed <= 1'b0;
      busy <= 1'b0;
      ps2_key_out <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      unwind <= unwind_d;
      key_q <= ps2_key_in[10];
      primed <= 1'b1;
      busy <= state != IDLE || count != '0;
      if (pop) cur <= mem[rp];
      if (live) ps2_key_out <= {~ps2_key_out[10], ps2_key_in[9:0]};
      else if (emit) ps2_key_out <= {~ps2_key_out[10], emit_press, 1'b0, emit_code};
    end
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      full <= 1'b0;
      overflow <= 1'b0;
    end else if (abort_t) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      full <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count_d;
      full <= count_d == CW'(FIFO_DEPTH);
      if (wr_en && full) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk_sys) begin
    if (push) mem[wp] <= wr_data;
  end
endmodule

// File: tb/tb_kbd_autotype.sv
// tb_kbd_autotype: directed vector table plus multi-cycle sequences for kbd_autotype
module tb_kbd_autotype;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;
  logic [10:0] ps2_key_in = '0;
  logic [10:0] ps2_key_out;
  logic wr_en = 1'b0;
  logic [8:0] wr_data = '0;
  logic abort = 1'b0;
  logic full, busy, overflow;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wn;
  logic prev = 1'b0;
  typedef struct {
    logic wr;
    logic [8:0] d;
    logic [10:0] exp_out;
    logic exp_busy;
  } vec_t;
  typedef struct {
    int cyc;
    logic [10:0] v;
  } ev_t;
  vec_t tv[12];
  ev_t ev[$];
  kbd_autotype #(.FIFO_DEPTH(4), .HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key_in(ps2_key_in), .ps2_key_out(ps2_key_out),
    .wr_en(wr_en), .wr_data(wr_data), .abort(abort), .full(full), .busy(busy), .overflow(overflow)
  );
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc++;
  always @(negedge clk_sys) begin
    if (reset_n && ps2_key_out[10] != prev) ev.push_back('{cyc, ps2_key_out});
    prev = ps2_key_out[10];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic wr(input logic [8:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic wait_idle(input int bound);
    int i;
    repeat (3) tick();
    for (i = 0; i < bound && busy; i++) tick();
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask
  task automatic chk_ev(input string nm, input int i, input int base, input int rel, input logic [9:0] v);
    if (i < ev.size()) begin
      chk({nm, "_cyc"}, 32'(ev[i].cyc - base), 32'(rel));
      chk({nm, "_code"}, 32'(ev[i].v[9:0]), 32'(v));
    end else chk({nm, "_missing"}, 32'(ev.size()), 32'(i + 1));
  endtask
  initial begin
    tv[0] = '{1'b0, 9'h000, 11'h000, 1'b0};
    tv[1] = '{1'b1, 9'h01C, 11'h000, 1'b0};
    tv[2] = '{1'b0, 9'h000, 11'h000, 1'b1};
    tv[3] = '{1'b0, 9'h000, 11'h61C, 1'b1};
    tv[4] = '{1'b0, 9'h000, 11'h61C, 1'b1};
    tv[5] = '{1'b0, 9'h000, 11'h61C, 1'b1};
    tv[6] = '{1'b0, 9'h000, 11'h61C, 1'b1};
    tv[7] = '{1'b0, 9'h000, 11'h61C, 1'b1};
    tv[8] = '{1'b0, 9'h000, 11'h01C, 1'b1};
    tv[9] = '{1'b0, 9'h000, 11'h01C, 1'b1};
    tv[10] = '{1'b0, 9'h000, 11'h01C, 1'b1};
    tv[11] = '{1'b0, 9'h000, 11'h01C, 1'b0};
    #1 reset_n = 1'b0;
    repeat (2) tick();
    chk("rst_out", 32'(ps2_key_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    reset_n = 1'b1;
    ev.delete();
    for (int i = 0; i < 12; i++) begin
      wr_en = tv[i].wr;
      wr_data = tv[i].d;
      tick();
      chk($sformatf("t1_out[%0d]", i), 32'(ps2_key_out), 32'(tv[i].exp_out));
      chk($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(tv[i].exp_busy));
      chk($sformatf("t1_full[%0d]", i), 32'(full), 32'h0);
    end
    wr_en = 1'b0;
    chk("t1_toggles", 32'(ev.size()), 32'd2);
    ev.delete();
    wr(9'h11E);
    wn = cyc;
    wait_idle(60);
    chk("t2_count", 32'(ev.size()), 32'd4);
    chk_ev("t2_sh_dn", 0, wn, 2, 10'h212);
    chk_ev("t2_key_dn", 1, wn, 3, 10'h21E);
    chk_ev("t2_key_up", 2, wn, 8, 10'h01E);
    chk_ev("t2_sh_up", 3, wn, 9, 10'h012);
    ev.delete();
    wr(9'h01C);
    wn = cyc;
    tick();
    ps2_key_in = {~ps2_key_in[10], 2'b00, 8'h29};
    wait_idle(60);
    chk("t3_count", 32'(ev.size()), 32'd3);
    chk_ev("t3_live", 0, wn, 2, 10'h029);
    chk_ev("t3_retry_dn", 1, wn, 3, 10'h21C);
    chk_ev("t3_up", 2, wn, 8, 10'h01C);
    ev.delete();
    wr(9'h01C);
    wn = cyc;
    tick();
    ps2_key_in = {~ps2_key_in[10], 2'b10, 8'h29};
    wait_idle(60);
    repeat (10) tick();
    chk("t3b_count", 32'(ev.size()), 32'd1);
    chk_ev("t3b_live_press", 0, wn, 2, 10'h229);
    ps2_key_in = {~ps2_key_in[10], 2'b00, 8'h29};
    repeat (3) tick();
    ev.delete();
    wr(9'h015);
    repeat (2) tick();
    wr(9'h01C);
    wr(9'h032);
    wr(9'h021);
    wr(9'h023);
    chk("t4_full", 32'(full), 32'h1);
    chk("t4_ovf_pre", 32'(overflow), 32'h0);
    wr(9'h024);
    chk("t4_ovf", 32'(overflow), 32'h1);
    wait_idle(300);
    chk("t4_count", 32'(ev.size()), 32'd10);
    begin
      logic [9:0] exp4[10] = '{10'h215, 10'h015, 10'h21C, 10'h01C, 10'h232, 10'h032, 10'h221, 10'h021, 10'h223, 10'h023};
      for (int i = 0; i < 10; i++)
        if (i < ev.size()) chk($sformatf("t4_ev[%0d]", i), 32'(ev[i].v[9:0]), 32'(exp4[i]));
    end
    chk("t4_ovf_sticky", 32'(overflow), 32'h1);
    ev.delete();
    wr(9'h11C);
    wn = cyc;
    wr(9'h01C);
    wr(9'h032);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_full", 32'(full), 32'h0);
    chk("t5_ovf_clr", 32'(overflow), 32'h0);
    chk("t5_busy", 32'(busy), 32'h1);
    wait_idle(60);
    repeat (20) tick();
    chk("t5_count", 32'(ev.size()), 32'd4);
    chk_ev("t5_sh_dn", 0, wn, 2, 10'h212);
    chk_ev("t5_key_dn", 1, wn, 3, 10'h21C);
    chk_ev("t5_key_up", 2, wn, 6, 10'h01C);
    chk_ev("t5_sh_up", 3, wn, 7, 10'h012);
    chk("t5_busy_end", 32'(busy), 32'h0);
    wr(9'h01C);
    wr(9'h032);
    repeat (3) tick();
    chk("t6_pressed", 32'(ps2_key_out[9]), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_out_async", 32'(ps2_key_out), 32'h0);
    chk("t6_busy_async", 32'(busy), 32'h0);
    chk("t6_full_async", 32'(full), 32'h0);
    ps2_key_in = {~ps2_key_in[10], 10'h000};
    repeat (2) tick();
    reset_n = 1'b1;
    ev.delete();
    repeat (15) tick();
    chk("t6_no_spurious", 32'(ev.size()), 32'd0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_out", 32'(ps2_key_out), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
